// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
//   Shared constants and types for the button conditioner.
//   - NUM_BTNS / BTN_* : channel count and bit positions in the packed
//                        {mins, hours, set} vectors used by the top level.
//   - DEF_*_CYCLES     : default timing constants (clock cycles).
//   - rpt_state_e      : per-channel auto-repeat state machine encoding.
//   - max_int          : helper used to size the shared repeat counter.
// ---------------------------------------------------------------------------
package button_pkg;

  localparam int NUM_BTNS  = 3;
  localparam int BTN_SET   = 0;
  localparam int BTN_HOURS = 1;
  localparam int BTN_MINS  = 2;

  localparam int DEF_DEBOUNCE_CYCLES      = 500000;
  localparam int DEF_REPEAT_DELAY_CYCLES  = 25000000;
  localparam int DEF_REPEAT_PERIOD_CYCLES = 10000000;

  typedef enum logic [1:0] {
    RPT_IDLE       = 2'd0,
    RPT_HOLD_DELAY = 2'd1,
    RPT_REPEAT     = 2'd2
  } rpt_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// ---------------------------------------------------------------------------
// button_channel
//   One conditioned push-button: 2-flop synchronizer, debounce counter,
//   rising-edge press pulse and an optional auto-repeat state machine.
//
// Parameters
//   DEBOUNCE_CYCLES      stable cycles needed to change the debounced level (>=2)
//   REPEAT_DELAY_CYCLES  cycles from press pulse to first repeat pulse (>=2)
//   REPEAT_PERIOD_CYCLES cycles between later repeat pulses (>=2)
//   REPEAT_EN            1: auto-repeat while held, 0: single press pulse only
//
// Ports
//   clk     in  clock
//   reset   in  synchronous active-high reset
//   raw_in  in  asynchronous, bouncy, active-high button
//   pulse   out one-cycle press / repeat pulse (forced low while reset is high)
//   level   out debounced button level
// ---------------------------------------------------------------------------
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter bit REPEAT_EN            = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic pulse,
  output logic level
);

  // Counters only ever hold 0 .. N-1: they are cleared on the cycle the
  // count would reach N, so $clog2(N) bits are enough and nothing wraps.
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES));

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

  logic [1:0]       sync_q,   sync_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             level_q,  level_d;
  rpt_state_e       state_q,  state_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             pulse_q,  pulse_d;

  logic sync_s;
  logic rise;
  logic fall;

  assign sync_s = sync_q[1];

  // Synchronizer and debounce.
  always_comb begin
    sync_d   = {sync_q[0], raw_in};
    db_cnt_d = '0;
    level_d  = level_q;
    rise     = 1'b0;
    fall     = 1'b0;
    if (sync_s != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        // The count would reach DEBOUNCE_CYCLES on this edge: accept the
        // new level and restart counting from zero.
        level_d  = ~level_q;
        db_cnt_d = '0;
        rise     = ~level_q;
        fall     = level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Press pulse and auto-repeat.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    pulse_d   = 1'b0;
    case (state_q)
      RPT_IDLE: begin
        rpt_cnt_d = '0;
        if (rise) begin
          pulse_d = 1'b1;
          state_d = RPT_HOLD_DELAY;
        end
      end
      RPT_HOLD_DELAY: begin
        if (fall) begin
          // Checked first so a repeat landing on the release is dropped.
          state_d   = RPT_IDLE;
          rpt_cnt_d = '0;
        end else if (REPEAT_EN) begin
          if (rpt_cnt_q == DELAY_LAST) begin
            pulse_d   = 1'b1;
            state_d   = RPT_REPEAT;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        // Without REPEAT_EN the channel parks here until release.
      end
      RPT_REPEAT: begin
        if (fall) begin
          state_d   = RPT_IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == PERIOD_LAST) begin
          pulse_d   = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = RPT_IDLE;
        rpt_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      state_q   <= RPT_IDLE;
      rpt_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  // A pulse registered just before reset asserts must not be seen by
  // downstream logic during the reset cycle itself.
  assign pulse = pulse_q & ~reset;
  assign level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Conditions the three clock-setting buttons. Each button gets its own
//   button_channel; hours and minutes auto-repeat while held, set_time
//   produces a single pulse per press. Channels are fully independent.
//
// Ports
//   clk            in  clock
//   reset          in  synchronous active-high reset
//   raw_set_time   in  bouncy set-time button
//   raw_inc_hours  in  bouncy hours button
//   raw_inc_mins   in  bouncy minutes button
//   btn_set_time   out one-cycle press pulse, never repeats
//   btn_inc_hours  out one-cycle press pulse, auto-repeats while held
//   btn_inc_mins   out one-cycle press pulse, auto-repeats while held
//   btn_level      out debounced levels {mins, hours, set}
// ---------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_set_time,
  input  logic       raw_inc_hours,
  input  logic       raw_inc_mins,
  output logic       btn_set_time,
  output logic       btn_inc_hours,
  output logic       btn_inc_mins,
  output logic [2:0] btn_level
);

  logic [NUM_BTNS-1:0] raw_vec;
  logic [NUM_BTNS-1:0] pulse_vec;
  logic [NUM_BTNS-1:0] level_vec;

  assign raw_vec[BTN_SET]   = raw_set_time;
  assign raw_vec[BTN_HOURS] = raw_inc_hours;
  assign raw_vec[BTN_MINS]  = raw_inc_mins;

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
      button_channel #(
        .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
        .REPEAT_EN            (gi != BTN_SET)
      ) u_chan (
        .clk    (clk),
        .reset  (reset),
        .raw_in (raw_vec[gi]),
        .pulse  (pulse_vec[gi]),
        .level  (level_vec[gi])
      );
    end
  endgenerate

  assign btn_set_time  = pulse_vec[BTN_SET];
  assign btn_inc_hours = pulse_vec[BTN_HOURS];
  assign btn_inc_mins  = pulse_vec[BTN_MINS];
  assign btn_level     = level_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed, table-driven bench for button_conditioner with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=5.
// Edge numbering: edge 1 is the first posedge sampling the new raw input;
// outputs are sampled 1 time unit after each posedge.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_set_time = 1'b0;
  logic       raw_inc_hours = 1'b0;
  logic       raw_inc_mins = 1'b0;
  logic       btn_set_time;
  logic       btn_inc_hours;
  logic       btn_inc_mins;
  logic [2:0] btn_level;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES      (4),
    .REPEAT_DELAY_CYCLES  (10),
    .REPEAT_PERIOD_CYCLES (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_set_time  (raw_set_time),
    .raw_inc_hours (raw_inc_hours),
    .raw_inc_mins  (raw_inc_mins),
    .btn_set_time  (btn_set_time),
    .btn_inc_hours (btn_inc_hours),
    .btn_inc_mins  (btn_inc_mins),
    .btn_level     (btn_level)
  );

  // raw / pulse / level vectors are all packed {mins, hours, set}
  typedef struct {
    string      name;
    int         edge_no;
    logic       rst;
    logic [2:0] raw;
    logic [2:0] exp_pulse;
    logic [2:0] exp_level;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [2:0] pulses();
    return {btn_inc_mins, btn_inc_hours, btn_set_time};
  endfunction

  function automatic void add(input string name, input int e, input logic rst,
                              input logic [2:0] raw, input logic [2:0] p,
                              input logic [2:0] l);
    vec_t v;
    v.name = name; v.edge_no = e; v.rst = rst;
    v.raw = raw; v.exp_pulse = p; v.exp_level = l;
    vecs.push_back(v);
  endfunction

  task automatic do_cycle(input logic rst, input logic [2:0] raw);
    @(negedge clk);
    reset         = rst;
    raw_set_time  = raw[0];
    raw_inc_hours = raw[1];
    raw_inc_mins  = raw[2];
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int e,
                       input logic [2:0] exp_p, input logic [2:0] exp_l);
    n_checks++;
    if (pulses() !== exp_p || btn_level !== exp_l) begin
      n_errors++;
      $display("FAIL %s edge %0d: pulse=%b level=%b, required pulse=%b level=%b",
               name, e, pulses(), btn_level, exp_p, exp_l);
    end else begin
      $display("ok   %s edge %0d: pulse=%b level=%b", name, e, pulses(), btn_level);
    end
  endtask

  initial begin
    // ---------------- build the vector table ----------------
    add("reset", 0, 1'b1, 3'b000, 3'b000, 3'b000);

    // Clean press on set_time, raw high edges 1-20.
    for (int e = 1; e <= 30; e++)
      add("clean", e, 1'b0, (e <= 20) ? 3'b001 : 3'b000,
          (e == 6) ? 3'b001 : 3'b000,
          (e >= 6 && e <= 25) ? 3'b001 : 3'b000);
    add("reset", 0, 1'b1, 3'b000, 3'b000, 3'b000);

    // Auto-repeat on minutes, raw high edges 1-40; the repeat due at
    // edge 46 coincides with the debounced fall and must be dropped.
    for (int e = 1; e <= 50; e++)
      add("repeat", e, 1'b0, (e <= 40) ? 3'b100 : 3'b000,
          (e == 6 || e == 16 || e == 21 || e == 26 || e == 31 || e == 36 || e == 41)
            ? 3'b100 : 3'b000,
          (e >= 6 && e <= 45) ? 3'b100 : 3'b000);
    add("reset", 0, 1'b1, 3'b000, 3'b000, 3'b000);

    // All three held edges 1-12: simultaneous press pulse, then only
    // hours/mins repeat at edge 16; all levels fall at edge 18.
    for (int e = 1; e <= 22; e++)
      add("simul", e, 1'b0, (e <= 12) ? 3'b111 : 3'b000,
          (e == 6) ? 3'b111 : ((e == 16) ? 3'b110 : 3'b000),
          (e >= 6 && e <= 17) ? 3'b111 : 3'b000);
    add("reset", 0, 1'b1, 3'b000, 3'b000, 3'b000);

    // Bounce on hours (3 high, 1 low, 3 high, low), then a 10-cycle hold
    // from edge 13: press at 18, fall at 28 which swallows the first repeat.
    for (int e = 1; e <= 35; e++)
      add("bounce", e, 1'b0,
          ((e <= 3) || (e >= 5 && e <= 7) || (e >= 13 && e <= 22)) ? 3'b010 : 3'b000,
          (e == 18) ? 3'b010 : 3'b000,
          (e >= 18 && e <= 27) ? 3'b010 : 3'b000);

    // ---------------- apply the table ----------------
    foreach (vecs[i]) begin
      do_cycle(vecs[i].rst, vecs[i].raw);
      check(vecs[i].name, vecs[i].edge_no, vecs[i].exp_pulse, vecs[i].exp_level);
    end

    // ---------------- reset in the middle of an hours hold ----------------
    do_cycle(1'b1, 3'b000);
    check("mid_rst_init", 0, 3'b000, 3'b000);
    for (int e = 1; e <= 30; e++) begin
      do_cycle(e == 12, 3'b010);
      check("mid_rst", e,
            (e == 6 || e == 18 || e == 28) ? 3'b010 : 3'b000,
            ((e >= 6 && e <= 11) || e >= 18) ? 3'b010 : 3'b000);
    end

    // ---------------- reset raised while a pulse is registered ----------------
    do_cycle(1'b1, 3'b000);
    for (int e = 1; e <= 6; e++) do_cycle(1'b0, 3'b100);
    check("pre_gate", 6, 3'b100, 3'b100);
    reset = 1'b1;
    #1;
    // Pulse must vanish immediately; level only clears at the next edge.
    check("gate_in_reset", 6, 3'b000, 3'b100);
    @(posedge clk);
    #1;
    check("gate_after_edge", 7, 3'b000, 3'b000);
    do_cycle(1'b0, 3'b000);
    check("gate_release", 8, 3'b000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
